// File: rtl/irrig_pump_arbiter_pkg.sv
// irrig_pkg: shared types for the irrigation pump arbiter.
// Zone count, zone index type, FSM state enum and small helpers.
package irrig_pkg;

  localparam int NZONES = 4;

  typedef logic [1:0] zone_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } irrig_state_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [NZONES-1:0] zone_onehot(zone_t z);
    return {{(NZONES-1){1'b0}}, 1'b1} << z;
  endfunction

endpackage

// File: rtl/irrig_pump_arbiter_if.sv
// irrig_pump_arbiter_if: zone requests / pump and valve controls.
// master: Rdy, Req, Fault out; slave (arbiter): Pump, Valve, Gnt, Busy, Done out.
interface irrig_pump_arbiter_if;
  import irrig_pkg::*;

  logic              Rdy;
  logic [NZONES-1:0] Req;
  logic              Fault;
  logic              Pump;
  logic [NZONES-1:0] Valve;
  zone_t             Gnt;
  logic              Busy;
  logic              Done;

  modport master (
    output Rdy, Req, Fault,
    input  Pump, Valve, Gnt, Busy, Done
  );

  modport slave (
    input  Rdy, Req, Fault,
    output Pump, Valve, Gnt, Busy, Done
  );

endinterface

// File: rtl/irrig_pump_arbiter_rr_pick.sv
// irrig_rr_pick: rotating priority encoder over the zone requests.
// in: req, ptr (highest-priority zone); out: gnt_idx, valid.
module irrig_rr_pick
  import irrig_pkg::*;
(
  input  logic [NZONES-1:0] req,
  input  zone_t             ptr,
  output zone_t             gnt_idx,
  output logic              valid
);

  zone_t cand;

  // Walk offsets from farthest to nearest so the nearest
  // set request (starting at ptr) is the last one to win.
  always_comb begin
    gnt_idx = ptr;
    valid   = 1'b0;
    cand    = ptr;
    for (int i = NZONES - 1; i >= 0; i--) begin
      cand = ptr + zone_t'(i);
      if (req[cand]) begin
        gnt_idx = cand;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrig_pump_arbiter.sv
// irrig_pump_arbiter: round-robin pump sharing, open/run/drain sequencing.
// in: Ck, Clr (async, high), bus.slave (Rdy, Req, Fault -> Pump, Valve, Gnt, Busy, Done).
module irrig_pump_arbiter
  import irrig_pkg::*;
#(
  parameter int T_OPEN  = 4,
  parameter int T_RUN   = 16,
  parameter int T_MIN   = 4,
  parameter int T_DRAIN = 2
) (
  input  logic Ck,
  input  logic Clr,
  irrig_pump_arbiter_if.slave bus
);

  localparam int TMAX = max2(max2(T_OPEN, T_RUN),
                             max2(T_MIN, T_DRAIN));
  localparam int CW   = $clog2(TMAX) + 1;

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_OPEN  = OPEN;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_FAULT = FAULT;

  if (T_OPEN < 1) begin : g_bad_open
    $error("T_OPEN must be at least 1");
  end
  if (T_RUN < 1) begin : g_bad_run
    $error("T_RUN must be at least 1");
  end
  if (T_MIN < 1 || T_MIN > T_RUN) begin : g_bad_min
    $error("T_MIN must be in 1..T_RUN");
  end
  if (T_DRAIN < 1) begin : g_bad_drain
    $error("T_DRAIN must be at least 1");
  end

  logic [2:0]        state;
  logic [2:0]        nstate;
  logic [CW-1:0]     cnt;
  zone_t             ptr;
  zone_t             gnt;
  zone_t             gnt_nxt;
  zone_t             pick_idx;
  logic              pick_vld;
  logic              pump_q;
  logic [NZONES-1:0] valve_q;
  logic              busy_q;
  logic              done_q;

  logic open_end;
  logic run_end;
  logic run_rel;
  logic drain_end;
  logic grant;
  logic done_nxt;
  logic active_nxt;
  logic cnt_hold;

  irrig_rr_pick u_pick (
    .req     (bus.Req),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .valid   (pick_vld)
  );

  assign open_end  = (cnt == CW'(T_OPEN - 1));
  assign run_end   = (cnt == CW'(T_RUN - 1));
  assign drain_end = (cnt == CW'(T_DRAIN - 1));

  // Zone satisfied: release early once the minimum run is met.
  assign run_rel = !bus.Req[gnt] && (cnt >= CW'(T_MIN - 1));

  // Fault outranks Rdy, which outranks the phase counters.
  always_comb begin
    nstate = state;
    if (bus.Fault) begin
      nstate = S_FAULT;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.Rdy && pick_vld) nstate = S_OPEN;
        end
        S_OPEN: begin
          if (!bus.Rdy)     nstate = S_DRAIN;
          else if (open_end) nstate = S_RUN;
        end
        S_RUN: begin
          if (!bus.Rdy || run_end || run_rel)
            nstate = S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_end) nstate = S_IDLE;
        end
        S_FAULT: nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  assign grant    = (state == S_IDLE) && (nstate == S_OPEN);
  assign done_nxt = (state == S_DRAIN) && (nstate == S_IDLE);
  assign gnt_nxt  = grant ? pick_idx : gnt;

  assign active_nxt = (nstate == S_OPEN) ||
                      (nstate == S_RUN)  ||
                      (nstate == S_DRAIN);

  // IDLE and FAULT can last indefinitely; keep cnt parked at 0.
  assign cnt_hold = (nstate != state) ||
                    (nstate == S_IDLE) ||
                    (nstate == S_FAULT);

  always_ff @(posedge Ck or posedge Clr) begin
    if (Clr) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      gnt     <= '0;
      pump_q  <= 1'b0;
      valve_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= nstate;
      cnt     <= cnt_hold ? '0 : cnt + 1'b1;
      gnt     <= gnt_nxt;
      if (done_nxt) ptr <= gnt + 1'b1;
      // Outputs decode the state being entered so they are
      // registered yet line up with the state itself.
      pump_q  <= (nstate == S_RUN);
      valve_q <= active_nxt ? zone_onehot(gnt_nxt) : '0;
      busy_q  <= active_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.Pump  = pump_q;
  assign bus.Valve = valve_q;
  assign bus.Gnt   = gnt;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_irrig_pump_arbiter.sv
// tb_irrig_pump_arbiter: randomized self-checking bench for the pump arbiter.
// Expected waveforms come from grant-level arithmetic on phase lengths.
module tb_irrig_pump_arbiter;
  import irrig_pkg::*;

  localparam int T_OPEN  = 4;
  localparam int T_RUN   = 16;
  localparam int T_MIN   = 4;
  localparam int T_DRAIN = 2;

  logic ck;
  logic clr;
  int   nchk = 0;
  int   nerr = 0;
  int   ptr_m = 0;
  zone_t last_z = '0;

  irrig_pump_arbiter_if bus ();

  irrig_pump_arbiter #(
    .T_OPEN  (T_OPEN),
    .T_RUN   (T_RUN),
    .T_MIN   (T_MIN),
    .T_DRAIN (T_DRAIN)
  ) dut (
    .Ck  (ck),
    .Clr (clr),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  logic [8:0] obs;
  assign obs = {bus.Pump, bus.Valve, bus.Gnt, bus.Busy, bus.Done};

  function automatic zone_t ref_pick(logic [3:0] m, int p);
    for (int i = 0; i < 4; i++)
      if (m[(p + i) % 4]) return zone_t'((p + i) % 4);
    return zone_t'(p);
  endfunction

  // kd: cycle index where the zone drops its request (0 = never)
  // rk: cycle index where Rdy drops (0 = never)
  function automatic int open_len(int rk);
    return (rk > 0 && rk <= T_OPEN) ? rk : T_OPEN;
  endfunction

  function automatic int run_len(int kd, int rk);
    int p;
    p = T_RUN;
    if (kd > 0) begin
      p = kd - T_OPEN;
      if (p < T_MIN) p = T_MIN;
      if (p > T_RUN) p = T_RUN;
    end
    if (rk > 0 && rk <= T_OPEN) p = 0;
    else if (rk > 0 && rk - T_OPEN < p) p = rk - T_OPEN;
    return p;
  endfunction

  // Expected {Pump, Valve, Gnt, Busy, Done} j cycles after the grant edge.
  function automatic logic [8:0] exp_vec(zone_t z, int j, int kd,
                                         int rk, int fk);
    int ol, p;
    logic [3:0] v;
    ol = open_len(rk);
    p  = run_len(kd, rk);
    v  = 4'b0001 << z;
    if (fk > 0 && j > fk) return {5'b0, z, 2'b00};
    if (j <= ol) return {1'b0, v, z, 2'b10};
    if (j <= ol + p) return {1'b1, v, z, 2'b10};
    if (j <= ol + p + T_DRAIN) return {1'b0, v, z, 2'b10};
    return {5'b0, z, 2'b01};
  endfunction

  // Starts at a falling edge with the DUT idle; ends on the first idle
  // cycle after the grant (Done cycle, or idle after a fault).
  task automatic run_grant(string tag, logic [3:0] mask, int kd, int rk,
                           int fk, int fl, bit jitter);
    zone_t z;
    int last;
    logic [8:0] e;
    logic [3:0] r;
    z = ref_pick(mask, ptr_m);
    if (fk > 0) last = fk + fl + 1;
    else last = open_len(rk) + run_len(kd, rk) + T_DRAIN + 1;
    bus.Req = mask;
    bus.Rdy = 1'b1;
    bus.Fault = 1'b0;
    for (int j = 1; j <= last; j++) begin
      @(negedge ck);
      e = exp_vec(z, j, kd, rk, fk);
      nchk++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL %s j=%0d got=%b exp=%b", tag, j, obs, e);
      end
      if (j < last) begin
        r = jitter ? 4'($urandom) : mask;
        r[z] = !(kd > 0 && j >= kd);
        bus.Req = r;
        if (rk > 0 && j >= rk) bus.Rdy = 1'b0;
        if (fk > 0) bus.Fault = (j >= fk && j < fk + fl);
      end
    end
    last_z = z;
    if (fk == 0) ptr_m = (int'(z) + 1) % 4;
  endtask

  task automatic idle_hold(string tag, int n, logic [3:0] r, logic rd);
    logic [8:0] e;
    bus.Req = r;
    bus.Rdy = rd;
    bus.Fault = 1'b0;
    e = {5'b0, last_z, 2'b00};
    for (int j = 1; j <= n; j++) begin
      @(negedge ck);
      nchk++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL %s j=%0d got=%b exp=%b", tag, j, obs, e);
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    bus.Req = 4'b1111;
    bus.Rdy = 1'b1;
    bus.Fault = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge ck);
      nchk++;
      if (obs !== 9'b0) begin
        nerr++;
        $display("FAIL reset j=%0d got=%b exp=%b", j, obs, 9'b0);
      end
    end
    clr = 1'b0;
    ptr_m = 0;
    last_z = '0;
    run_grant("reset_release", 4'b1111, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_full_grant;
    run_grant("full_grant", 4'b0100, 0, 0, 0, 0, 1'b0);
    run_grant("full_regrant", 4'b0100, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_early_release;
    run_grant("early_min", 4'b0010, T_OPEN + 3, 0, 0, 0, 1'b0);
    run_grant("early_ten", 4'b0010, T_OPEN + 10, 0, 0, 0, 1'b0);
    run_grant("drop_in_open", 4'b0010, 2, 0, 0, 0, 1'b0);
  endtask

  task automatic test_round_robin;
    for (int n = 0; n < 5; n++)
      run_grant("rr_all", 4'b1111, 0, 0, 0, 0, 1'b0);
    for (int n = 0; n < 4 && last_z != 2'd1; n++)
      run_grant("rr_seek", 4'b1111, 0, 0, 0, 0, 1'b0);
    run_grant("rr_1010", 4'b1010, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_fault;
    run_grant("fault_run", 4'b1111, 0, 0, T_OPEN + 6, 5, 1'b0);
    run_grant("fault_retry", 4'b1111, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_rdy_loss;
    run_grant("rdy_open", 4'b0010, 0, 2, 0, 0, 1'b0);
    idle_hold("rdy_low_idle", 6, 4'b0010, 1'b0);
    run_grant("rdy_run", 4'b0010, 0, T_OPEN + 3, 0, 0, 1'b0);
    idle_hold("rdy_low_idle2", 3, 4'b1111, 1'b0);
  endtask

  task automatic test_clr_mid;
    zone_t z;
    logic [8:0] e;
    z = ref_pick(4'b0100, ptr_m);
    bus.Req = 4'b0100;
    bus.Rdy = 1'b1;
    bus.Fault = 1'b0;
    repeat (T_OPEN + 2) @(negedge ck);
    e = exp_vec(z, T_OPEN + 2, 0, 0, 0);
    nchk++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL clr_pre got=%b exp=%b", obs, e);
    end
    #2 clr = 1'b1;
    #1;
    nchk++;
    if (obs !== 9'b0) begin
      nerr++;
      $display("FAIL clr_async got=%b exp=%b", obs, 9'b0);
    end
    @(negedge ck);
    nchk++;
    if (obs !== 9'b0) begin
      nerr++;
      $display("FAIL clr_hold got=%b exp=%b", obs, 9'b0);
    end
    bus.Req = 4'b0000;
    clr = 1'b0;
    ptr_m = 0;
    last_z = '0;
    run_grant("after_clr", 4'b0100, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] m;
      int kd, rk, fk, fl, tot;
      m  = 4'($urandom_range(1, 15));
      kd = ($urandom_range(0, 2) == 0) ? 0 :
           int'($urandom_range(1, T_OPEN + T_RUN));
      rk = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(1, T_OPEN + T_RUN)) : 0;
      fk = 0;
      fl = 0;
      if ($urandom_range(0, 4) == 0) begin
        tot = open_len(rk) + run_len(kd, rk) + T_DRAIN;
        fk  = int'($urandom_range(1, tot));
        fl  = int'($urandom_range(1, 4));
      end
      run_grant("random", m, kd, rk, fk, fl, 1'b1);
      if ($urandom_range(0, 3) == 0)
        idle_hold("random_gap", int'($urandom_range(1, 3)),
                  4'b0000, 1'b1);
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.Req = '0;
    bus.Rdy = 1'b0;
    bus.Fault = 1'b0;
    test_reset;
    test_full_grant;
    test_early_release;
    test_round_robin;
    test_fault;
    test_rdy_loss;
    test_clr_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/irrig_pump_arbiter.md
# irrig_pump_arbiter

Shares the farm's single irrigation pump among four field zones. Each zone raises a request from its soil-moisture sensor. The block grants one zone at a time in round-robin order and sequences that zone's valve and the pump through open, run and drain phases with programmable phase lengths. It sits downstream of the initialization FSM: no new grant is issued until that FSM reports ready.

## Interface
- `T_OPEN`, default 4: cycles the valve is open before the pump starts (≥1).
- `T_RUN`, default 16: maximum pump-on cycles per grant (≥1).
- `T_MIN`, default 4: minimum pump-on cycles per grant (1 ≤ `T_MIN` ≤ `T_RUN`).
- `T_DRAIN`, default 2: cycles with the pump off and the valve still open before the valve closes (≥1).
- `Ck` in, 1 bit: system clock, rising edge.
- `Clr` in, 1 bit: reset, asynchronous and active-high.
- `Rdy` in, 1 bit: system ready, from the initialization FSM's H1 output.
- `Req` in, 4 bits: zone requests, bit i = zone i needs water; synchronous and level-held.
- `Fault` in, 1 bit: pump fault or overpressure; synchronous; highest priority.
- `Pump` out, 1 bit: pump motor enable.
- `Valve` out, 4 bits: zone valves, one-hot or zero.
- `Gnt` out, 2 bits: index of the current or last granted zone.
- `Busy` out, 1 bit: a grant is in progress (OPEN, RUN or DRAIN).
- `Done` out, 1 bit: one-cycle pulse when a grant completes normally.

## Operation
- States: IDLE, OPEN, RUN, DRAIN, FAULT. Phase counter `cnt` clears on every state entry.
- All outputs are registered and Moore-decoded from state and `Gnt`:
  - `Valve[Gnt]` = 1 in OPEN, RUN and DRAIN.
  - `Pump` = 1 only in RUN.
  - `Busy` = 1 in OPEN, RUN and DRAIN.
- IDLE → OPEN when `Rdy`=1, `Req`≠0 and `Fault`=0.
  - `Gnt` is loaded with the first set `Req` bit, searching ptr, ptr+1, … mod 4.
- OPEN → RUN when `cnt`=`T_OPEN`−1.
- RUN → DRAIN on either condition:
  - `cnt`=`T_RUN`−1, or
  - `Req[Gnt]`=0 and `cnt`≥`T_MIN`−1 (early release once the zone is satisfied).
- DRAIN → IDLE when `cnt`=`T_DRAIN`−1. On this transition:
  - `Done`=1 for one cycle;
  - ptr ← `Gnt`+1 mod 4.
- `Rdy`=0 while in OPEN or RUN: go to DRAIN on the next edge, ignoring `T_MIN`. DRAIN then completes normally, `Done` pulses and ptr advances.
- `Fault`=1 in any state: go to FAULT on the next edge.
  - In FAULT, `Pump`=0, `Valve`=0000, `Busy`=0 and no `Done` is issued.
  - ptr is not advanced, so the interrupted zone is served first on retry.
  - FAULT → IDLE on the first edge that samples `Fault`=0.
- `Fault` beats `Rdy`, which beats the counter conditions.
- A request dropping in OPEN does not abort the grant; `T_MIN` still applies in RUN.
- `Req` changes on other zones during a grant are ignored until the block is back in IDLE.
- IDLE lasts at least one cycle between grants.

## Timing
- `Clr`=1 forces, immediately and asynchronously: IDLE, ptr=0, `cnt`=0, `Pump`=0, `Valve`=0000, `Gnt`=00, `Busy`=0, `Done`=0.
- `Clr` asserted mid-grant drops `Pump` and `Valve` without draining.
- Edge e0 samples a qualifying request in IDLE. From then:
  - `Valve` and `Busy` are high after e0;
  - `Pump` rises after e0+`T_OPEN`;
  - a full-length run holds `Pump` high for exactly `T_RUN` cycles;
  - `Valve` stays open `T_DRAIN` cycles after `Pump` falls;
  - `Done` is high in the first IDLE cycle.
- Full grant latency with defaults: 4+16+2 = 22 cycles of `Busy`.
- Minimum pump-on time is `T_MIN` cycles, except on a `Rdy` drop, `Fault` or `Clr`.
- `cnt` width is $clog2 of the largest parameter, plus 1. It never wraps because every state exits at its terminal count.

## Structure
- Package `irrig_pkg` holds:
  - `NZONES`=4;
  - the state enum `irrig_state_t` (IDLE, OPEN, RUN, DRAIN, FAULT);
  - the zone index type `zone_t` (2 bits).
- Sub-module `irrig_rr_pick`: combinational rotating priority encoder.
  - Inputs: `Req[3:0]`, ptr.
  - Outputs: grant index, valid.
- The top module holds the FSM, the phase counter, ptr and the output registers.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- Reset: `Clr`=1 with `Req`=1111, `Rdy`=1 → all outputs 0 and `Gnt`=00. Releasing `Clr` → `Valve`=0001 one edge later.
- Single full grant: `Req`=0100 held, `Rdy`=1 →
  - `Valve`=0100 and `Gnt`=10 after e0;
  - `Pump`=1 for cycles 4–19 after e0;
  - `Valve` closes after e0+22, with `Done`=1 for one cycle;
  - the same zone is re-granted after one IDLE cycle.
- Early release: `Req`=0010, dropped 2 cycles into RUN → `Pump` stays high 4 cycles (`T_MIN`), then DRAIN 2 cycles and `Done`. Dropping after 9 RUN cycles → `Pump` high exactly 10 cycles.
- Round-robin: `Req`=1111 held → successive `Gnt` = 0, 1, 2, 3, 0, each with a `Done` pulse. `Req`=1010 after `Gnt`=1 → next `Gnt`=3.
- Fault: `Fault`=1 for 5 cycles mid-RUN of zone 2 → next edge `Pump`=0, `Valve`=0000, no `Done`. After `Fault` falls, zone 2 is re-granted first with `Req`=1111.
- `Rdy` loss: `Rdy`→0 in OPEN of zone 1 → DRAIN 2 cycles with `Pump` never high, `Done` pulses, and no new grant while `Rdy`=0.
